// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states,
// the one-hot result encoding and the cascade priority resolver.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } res_t;

  localparam res_t RES_NONE = '{lt: 1'b0, gt: 1'b0, eq: 1'b0};
  localparam res_t RES_LT   = '{lt: 1'b1, gt: 1'b0, eq: 1'b0};
  localparam res_t RES_GT   = '{lt: 1'b0, gt: 1'b1, eq: 1'b0};
  localparam res_t RES_EQ   = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};

  // Equality from the lower stage dominates, then less-than, then greater-than.
  function automatic res_t resolve_cascade(input logic ceq, input logic clt, input logic cgt);
    res_t r;
    if (ceq)
      r = RES_EQ;
    else if (clt)
      r = RES_LT;
    else if (cgt)
      r = RES_GT;
    else
      r = RES_NONE;
    return r;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             c_lt,
  output logic             c_gt,
  output logic             c_eq
);

  assign c_lt = (a < b);
  assign c_gt = (a > b);
  assign c_eq = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle wide magnitude comparator: scans captured operands CHUNK bits
// per cycle from the MSB, stopping at the first differing chunk.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             cas_lt,
  input  logic             cas_gt,
  input  logic             cas_eq,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] flip;
  logic [IDXW-1:0]  idx_reg;
  logic             cas_lt_reg, cas_gt_reg, cas_eq_reg;
  res_t             res_reg, res_next;
  logic             done_reg, done_next;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_sel, b_sel;
  logic             c_lt, c_gt, c_eq;
  logic             accept, last;

  assign accept = (state_reg == IDLE) && start;
  assign last   = (idx_reg == '0);

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign a_sel = a_chunk[idx_reg];
  assign b_sel = b_chunk[idx_reg];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a    (a_sel),
    .b    (b_sel),
    .c_lt (c_lt),
    .c_gt (c_gt),
    .c_eq (c_eq)
  );

  // Flipping the sign bit maps two's complement onto offset binary,
  // so the scan itself is always unsigned.
  always_comb begin
    flip            = '0;
    flip[WIDTH-1]   = signed_mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!c_eq || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_next  = res_reg;
    done_next = 1'b0;
    if (state_reg == RUN) begin
      if (c_gt) begin
        res_next  = RES_GT;
        done_next = 1'b1;
      end else if (c_lt) begin
        res_next  = RES_LT;
        done_next = 1'b1;
      end else if (last) begin
        res_next  = resolve_cascade(cas_eq_reg, cas_lt_reg, cas_gt_reg);
        done_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= '0;
      cas_lt_reg <= 1'b0;
      cas_gt_reg <= 1'b0;
      cas_eq_reg <= 1'b0;
      res_reg    <= RES_NONE;
      done_reg   <= 1'b0;
    end else begin
      res_reg  <= res_next;
      done_reg <= done_next;
      if (accept) begin
        a_reg      <= a ^ flip;
        b_reg      <= b ^ flip;
        idx_reg    <= IDXW'(NCHUNK - 1);
        cas_lt_reg <= cas_lt;
        cas_gt_reg <= cas_gt;
        cas_eq_reg <= cas_eq;
      end else if ((state_reg == RUN) && c_eq && !last) begin
        idx_reg <= idx_reg - 1'b1;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign lt   = res_reg.lt;
  assign gt   = res_reg.gt;
  assign eq   = res_reg.eq;

endmodule
